// File: rtl/chipinvaders_pkg.sv
// Shared button indices, default timing constants and counter sizing helper
// for the push-button conditioning path.
package chipinvaders_pkg;

    typedef enum logic [1:0] {
        BTN_UP    = 2'd0,
        BTN_LEFT  = 2'd1,
        BTN_RIGHT = 2'd2
    } btn_idx_e;

    localparam int NUM_BTN             = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_REPEAT_DELAY    = 12500000;
    localparam int DEF_REPEAT_PERIOD   = 2500000;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Bits needed to hold 0..n_vals-1 (never less than one bit).
    function automatic int cnt_width(input int n_vals);
        return (n_vals <= 2) ? 1 : $clog2(n_vals);
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Raw key inputs and conditioned button outputs of btn_conditioner.
interface btn_conditioner_if;
    logic key_up;
    logic key_left;
    logic key_right;
    logic btn_u;
    logic btn_l;
    logic btn_r;
    logic press_u;
    logic press_l;
    logic press_r;

    modport master (
        output key_up, key_left, key_right,
        input  btn_u, btn_l, btn_r, press_u, press_l, press_r
    );

    modport slave (
        input  key_up, key_left, key_right,
        output btn_u, btn_l, btn_r, press_u, press_l, press_r
    );
endinterface

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, stability counter, registered level
// and press pulse; i_rpt lets an external repeat FSM request extra pulses.
module btn_debounce
    import chipinvaders_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    input  logic i_rpt,
    output logic o_btn,
    output logic o_press
);
    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_lvl;
    logic [CW-1:0] r_cnt;
    logic          r_btn;
    logic          r_press;
    logic          w_rise;

    // r_lvl leads r_btn by one cycle, so the edge is known before it is visible.
    assign w_rise = r_lvl & ~r_btn;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_lvl   <= 1'b0;
            r_cnt   <= '0;
            r_btn   <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_s1  <= i_key;
            r_s2  <= r_s1;
            if (r_s2 == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt >= CNT_LAST) begin
                r_lvl <= ~r_lvl;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_btn   <= r_lvl;
            // Repeat requests only land while the level is high and not falling.
            r_press <= w_rise | (i_rpt & r_lvl & r_btn);
        end
    end

    assign o_btn   = r_btn;
    assign o_press = r_press;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces the up/left/right keys into levels and one-cycle press pulses.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat on the left and right keys.
module btn_conditioner
    import chipinvaders_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               rst,
    btn_conditioner_if.slave   bus
);
    logic [NUM_BTN-1:0] w_key;
    logic [NUM_BTN-1:0] w_btn;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_rpt;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 20) ||
        REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("btn_conditioner: timing parameter out of range");
    end

    assign w_key[BTN_UP]    = bus.key_up;
    assign w_key[BTN_LEFT]  = bus.key_left;
    assign w_key[BTN_RIGHT] = bus.key_right;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .i_key   (w_key[gi]),
            .i_rpt   (w_rpt[gi]),
            .o_btn   (w_btn[gi]),
            .o_press (w_press[gi])
        );
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = cnt_width(RPT_MAX + 1);

    assign w_rpt[BTN_UP] = 1'b0;

    // r_cnt counts edges since the last pulse as seen from the next edge;
    // r_req is raised one cycle ahead so the pulse lands on the due edge.
    for (genvar gi = 1; gi < NUM_BTN; gi++) begin : g_rpt
        rpt_state_e    r_state;
        logic [RW-1:0] r_cnt;
        logic          r_req;
        logic [RW-1:0] w_cnt_inc;

        assign w_cnt_inc = (r_cnt == RW'(RPT_MAX)) ? r_cnt : r_cnt + RW'(1);
        assign w_rpt[gi] = r_req;

        always_ff @(posedge clk) begin
            if (rst || !w_btn[gi]) begin
                r_state <= RPT_IDLE;
                r_cnt   <= '0;
                r_req   <= 1'b0;
            end else begin
                case (r_state)
                    RPT_IDLE: begin
                        if (w_press[gi]) begin
                            r_state <= RPT_DELAY;
                            r_cnt   <= RW'(2);
                            r_req   <= (REPEAT_DELAY == 2);
                        end
                    end
                    RPT_DELAY: begin
                        if (r_req) begin
                            r_state <= RPT_REPEAT;
                            r_cnt   <= RW'(1);
                            r_req   <= (REPEAT_PERIOD == 1);
                        end else begin
                            r_cnt   <= w_cnt_inc;
                            r_req   <= (w_cnt_inc == RW'(REPEAT_DELAY));
                        end
                    end
                    RPT_REPEAT: begin
                        if (r_req) begin
                            r_cnt   <= RW'(1);
                            r_req   <= (REPEAT_PERIOD == 1);
                        end else begin
                            r_cnt   <= w_cnt_inc;
                            r_req   <= (w_cnt_inc == RW'(REPEAT_PERIOD));
                        end
                    end
                    default: begin
                        r_state <= RPT_IDLE;
                        r_cnt   <= '0;
                        r_req   <= 1'b0;
                    end
                endcase
            end
        end
    end
`else
    assign w_rpt = '0;
`endif

    assign bus.btn_u   = w_btn[BTN_UP];
    assign bus.btn_l   = w_btn[BTN_LEFT];
    assign bus.btn_r   = w_btn[BTN_RIGHT];
    assign bus.press_u = w_press[BTN_UP];
    assign bus.press_l = w_press[BTN_LEFT];
    assign bus.press_r = w_press[BTN_RIGHT];

endmodule
